// File: rtl/carbon_dbg_pkg.sv
// rtl/carbon_dbg_pkg.sv - shared FSM type and trace record layout for core_dbg_agent
package carbon_dbg_pkg;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_HALTING    = 3'd1,
    ST_HALTED     = 3'd2,
    ST_STEP_ISSUE = 3'd3,
    ST_STEP_WAIT  = 3'd4
  } dbg_state_e;

  // PC sits at [ADDR_W-1:0]; the remaining field offsets are relative to ADDR_W.
  localparam int TR_PC_LSB       = 0;
  localparam int TR_INSN_OFS     = 0;
  localparam int TR_INSN_W       = 32;
  localparam int TR_DROP_OFS     = TR_INSN_OFS + TR_INSN_W;
  localparam int TR_DROP_W       = 8;
  localparam int TR_SEQ_OFS      = TR_DROP_OFS + TR_DROP_W;
  localparam int TR_SEQ_W        = 16;
  localparam int TRACE_REC_MIN_W = TR_SEQ_OFS + TR_SEQ_W;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - single-clock first-word-fall-through record FIFO with full/empty flags
module trace_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_tvalid,
  input  logic [W-1:0] s_tdata,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = s_tvalid && !full;
  assign do_pop  = m_tready && !empty;
  assign m_tdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= s_tdata;
  end

endmodule

// File: rtl/core_dbg_agent.sv
// rtl/core_dbg_agent.sv - core debug agent: halt/step handshake and retirement trace (trace under CARBON_DBG_TRACE_EN)
module core_dbg_agent
  import carbon_dbg_pkg::*;
#(
  parameter int ADDR_W           = 32,
  parameter int TRACE_W          = 128,
  parameter int TRACE_FIFO_DEPTH = 4,
  parameter int STEP_TIMEOUT     = 64,
  parameter int RESET_HALT       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt_req,
  input  logic               run_req,
  input  logic               step_req,
  output logic               halt_ack,
  output logic               step_ack,
  output logic               step_timeout,
  output logic               core_hold,
  output logic               core_step,
  input  logic               core_quiesced,
  input  logic               core_retire_valid,
  input  logic [ADDR_W-1:0]  core_retire_pc,
  input  logic [31:0]        core_retire_insn,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [TRACE_W-1:0] trace_data
);

  localparam dbg_state_e RESET_STATE = (RESET_HALT != 0) ? ST_HALTED : ST_RUN;
  localparam int         CNT_W       = $clog2(STEP_TIMEOUT + 1);

  dbg_state_e       state;
  dbg_state_e       state_nxt;
  logic [CNT_W-1:0] step_cnt;
  logic             step_seen;
  logic             seen_now;
  logic             step_done;
  logic             step_expired;

  // A retirement in the current cycle counts as seen, so quiesce may coincide with it.
  assign seen_now     = step_seen | core_retire_valid;
  assign step_done    = seen_now & core_quiesced;
  assign step_expired = !seen_now && (step_cnt == CNT_W'(STEP_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:        if (halt_req) state_nxt = ST_HALTING;
      ST_HALTING:    if (core_quiesced) state_nxt = ST_HALTED;
      ST_HALTED: begin
        if (step_req)                  state_nxt = ST_STEP_ISSUE;
        else if (!halt_req && run_req) state_nxt = ST_RUN;
      end
      ST_STEP_ISSUE: state_nxt = ST_STEP_WAIT;
      ST_STEP_WAIT:  if (step_done || step_expired) state_nxt = ST_HALTED;
      default:       state_nxt = ST_HALTED;
    endcase
  end

  always_comb begin
    halt_ack  = (state == ST_HALTED);
    core_hold = (state != ST_RUN);
    core_step = (state == ST_STEP_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt     <= '0;
      step_seen    <= 1'b0;
      step_ack     <= 1'b0;
      step_timeout <= 1'b0;
    end else begin
      step_ack <= (state == ST_STEP_WAIT) && (state_nxt == ST_HALTED);
      if (state == ST_HALTED && step_req)               step_timeout <= 1'b0;
      else if (state == ST_STEP_WAIT && step_expired)   step_timeout <= 1'b1;
      if (state == ST_STEP_ISSUE) begin
        step_cnt  <= '0;
        step_seen <= 1'b0;
      end else if (state == ST_STEP_WAIT) begin
        step_seen <= seen_now;
        if (step_cnt != CNT_W'(STEP_TIMEOUT)) step_cnt <= step_cnt + 1'b1;
      end
    end
  end

`ifdef CARBON_DBG_TRACE_EN
  logic [TR_SEQ_W-1:0]  seq;
  logic [TR_DROP_W-1:0] drop_cnt;
  logic [TRACE_W-1:0]   rec;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;

  // Full is the registered flag, so a same-cycle pop never rescues a push into a full FIFO.
  assign push        = core_retire_valid & ~fifo_full;
  assign trace_valid = ~fifo_empty;

  always_comb begin
    rec = '0;
    rec[TR_PC_LSB +: ADDR_W]                 = core_retire_pc;
    rec[ADDR_W + TR_INSN_OFS +: TR_INSN_W]   = core_retire_insn;
    rec[ADDR_W + TR_DROP_OFS +: TR_DROP_W]   = drop_cnt;
    rec[ADDR_W + TR_SEQ_OFS +: TR_SEQ_W]     = seq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq      <= '0;
      drop_cnt <= '0;
    end else if (core_retire_valid) begin
      seq <= seq + 1'b1;
      if (push)                  drop_cnt <= '0;
      else if (drop_cnt != '1)   drop_cnt <= drop_cnt + 1'b1;
    end
  end

  trace_fifo #(
    .W     (TRACE_W),
    .DEPTH (TRACE_FIFO_DEPTH)
  ) u_trace_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (push),
    .s_tdata  (rec),
    .m_tready (trace_ready),
    .m_tdata  (trace_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
`else
  localparam int unused_fifo_depth = TRACE_FIFO_DEPTH;
  logic unused_trace;

  assign unused_trace = ^{core_retire_pc, core_retire_insn, trace_ready};
  assign trace_valid  = 1'b0;
  assign trace_data   = '0;
`endif

endmodule

// File: tb/tb_core_dbg_agent.sv
// tb/tb_core_dbg_agent.sv - self-checking bench for core_dbg_agent with a queue-based trace model
module tb_core_dbg_agent;

  localparam int ADDR_W = 32;
  localparam int TRACE_W = 128;
  localparam int DEPTH = 4;
  localparam int STO = 8;
`ifdef CARBON_DBG_TRACE_EN
  localparam bit TRACE_EN = 1'b1;
`else
  localparam bit TRACE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halt_req = 1'b0, run_req = 1'b0, step_req = 1'b0;
  logic core_quiesced = 1'b0, core_retire_valid = 1'b0, trace_ready = 1'b0;
  logic [ADDR_W-1:0] core_retire_pc = '0;
  logic [31:0] core_retire_insn = '0;
  logic halt_ack, step_ack, step_timeout, core_hold, core_step, trace_valid;
  logic [TRACE_W-1:0] trace_data;
  logic rh_halt_ack, rh_core_hold, rh_core_step, rh_step_ack;
  logic unused_rh_step_timeout, unused_rh_trace_valid;
  logic [TRACE_W-1:0] unused_rh_trace_data;

  int vectors = 0;
  int miscompares = 0;
  logic [TRACE_W-1:0] rec_q [$];
  int m_seq = 0;
  int m_drop = 0;
  int n;

  always #5 clk = ~clk;

  core_dbg_agent #(
    .ADDR_W(ADDR_W), .TRACE_W(TRACE_W), .TRACE_FIFO_DEPTH(DEPTH),
    .STEP_TIMEOUT(STO), .RESET_HALT(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .run_req(run_req), .step_req(step_req),
    .halt_ack(halt_ack), .step_ack(step_ack), .step_timeout(step_timeout),
    .core_hold(core_hold), .core_step(core_step), .core_quiesced(core_quiesced),
    .core_retire_valid(core_retire_valid), .core_retire_pc(core_retire_pc),
    .core_retire_insn(core_retire_insn), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_data(trace_data)
  );

  core_dbg_agent #(
    .ADDR_W(ADDR_W), .TRACE_W(TRACE_W), .TRACE_FIFO_DEPTH(DEPTH),
    .STEP_TIMEOUT(STO), .RESET_HALT(1)
  ) u_dut_rh (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .run_req(run_req), .step_req(step_req),
    .halt_ack(rh_halt_ack), .step_ack(rh_step_ack), .step_timeout(unused_rh_step_timeout),
    .core_hold(rh_core_hold), .core_step(rh_core_step), .core_quiesced(core_quiesced),
    .core_retire_valid(core_retire_valid), .core_retire_pc(core_retire_pc),
    .core_retire_insn(core_retire_insn), .trace_valid(unused_rh_trace_valid),
    .trace_ready(trace_ready), .trace_data(unused_rh_trace_data)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control outputs packed as {halt_ack, core_hold, core_step, step_ack, step_timeout}.
  task automatic chk_ctrl(input string tag, input logic [4:0] exp);
    check(tag, 128'({halt_ack, core_hold, core_step, step_ack, step_timeout}), 128'(exp));
  endtask

  function automatic logic [TRACE_W-1:0] mk_rec(input logic [31:0] pc, input logic [31:0] insn,
                                               input int drop, input int seq);
    logic [TRACE_W-1:0] r;
    r = '0;
    r[31:0]  = pc;
    r[63:32] = insn;
    r[71:64] = 8'(drop);
    r[87:72] = 16'(seq);
    return r;
  endfunction

  // One clock: update the reference model from the applied inputs, then compare the trace port.
  task automatic tick();
    bit was_full;
    bit exp_valid;
    was_full = (rec_q.size() == DEPTH);
    if (rec_q.size() != 0 && trace_ready) void'(rec_q.pop_front());
    if (core_retire_valid) begin
      if (!was_full) begin
        rec_q.push_back(mk_rec(core_retire_pc, core_retire_insn, m_drop, m_seq));
        m_drop = 0;
      end else if (m_drop < 255) begin
        m_drop++;
      end
      m_seq = (m_seq + 1) % 65536;
    end
    @(posedge clk);
    @(negedge clk);
    exp_valid = TRACE_EN && (rec_q.size() != 0);
    check("trace_valid", 128'(trace_valid), 128'(exp_valid));
    check("trace_data", trace_valid ? trace_data : '0, exp_valid ? rec_q[0] : '0);
  endtask

  task automatic retire_tick();
    core_retire_valid = 1'b1;
    core_retire_pc = $urandom;
    core_retire_insn = $urandom;
    tick();
    core_retire_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_ctrl("rst_ctrl", 5'b00000);
    check("rst_tvalid", 128'(trace_valid), 128'(1'b0));
    check("rst_tdata", trace_data, '0);
    check("rst_halt_variant", 128'({rh_halt_ack, rh_core_hold, rh_core_step, rh_step_ack}), 128'(4'b1100));
    rst_n = 1'b1;
    trace_ready = 1'b1;
    tick();
    chk_ctrl("run_idle", 5'b00000);

    halt_req = 1'b1;
    tick();
    chk_ctrl("halt_hold", 5'b01000);
    tick();
    tick();
    chk_ctrl("halting_wait", 5'b01000);
    core_quiesced = 1'b1;
    tick();
    chk_ctrl("halt_ack", 5'b11000);
    run_req = 1'b1;
    tick();
    tick();
    chk_ctrl("halt_run_both", 5'b11000);
    halt_req = 1'b0;
    tick();
    chk_ctrl("resume", 5'b00000);
    run_req = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk_ctrl("step_in_run", 5'b00000);

    halt_req = 1'b1;
    tick();
    tick();
    chk_ctrl("rehalt", 5'b11000);
    step_req = 1'b1;
    core_quiesced = 1'b0;
    tick();
    step_req = 1'b0;
    chk_ctrl("step_issue", 5'b01100);
    tick();
    chk_ctrl("step_wait", 5'b01000);
    core_retire_valid = 1'b1;
    core_retire_pc = 32'h100;
    core_retire_insn = $urandom;
    tick();
    core_retire_valid = 1'b0;
    chk_ctrl("step_retired", 5'b01000);
    check("step_pc", 128'(trace_data[31:0]), TRACE_EN ? 128'h100 : '0);
    check("step_seq", 128'(trace_data[87:72]), '0);
    core_quiesced = 1'b1;
    tick();
    chk_ctrl("step_ack", 5'b11010);
    tick();
    chk_ctrl("step_ack_pulse", 5'b11000);

    step_req = 1'b1;
    core_quiesced = 1'b0;
    tick();
    step_req = 1'b0;
    chk_ctrl("to_issue", 5'b01100);
    n = 0;
    while (!step_ack && n < 40) begin
      tick();
      n++;
    end
    // STO cycles in STEP_WAIT, then step_ack shows in the first HALTED cycle.
    check("to_latency", 128'(n), 128'(STO + 1));
    chk_ctrl("to_done", 5'b11011);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk_ctrl("to_clear", 5'b01100);
    tick();
    retire_tick();
    core_quiesced = 1'b1;
    tick();
    chk_ctrl("to_step_ack", 5'b11010);

    trace_ready = 1'b0;
    retire_tick();
    retire_tick();
    step_req = 1'b1;
    core_quiesced = 1'b0;
    tick();
    step_req = 1'b0;
    tick();
    chk_ctrl("mid_wait", 5'b01000);
    rst_n = 1'b0;
    #1;
    chk_ctrl("mid_rst_ctrl", 5'b00000);
    check("mid_rst_tvalid", 128'(trace_valid), 128'(1'b0));
    check("mid_rst_tdata", trace_data, '0);
    rec_q.delete();
    m_seq = 0;
    m_drop = 0;
    halt_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) retire_tick();
    check("ovf_valid", 128'(trace_valid), 128'(TRACE_EN));
    trace_ready = 1'b1;
    repeat (4) tick();
    check("ovf_drained", 128'(trace_valid), 128'(1'b0));
    retire_tick();
    check("ovf_drop", 128'(trace_data[71:64]), TRACE_EN ? 128'd2 : '0);
    check("ovf_seq", 128'(trace_data[87:72]), TRACE_EN ? 128'd6 : '0);
    tick();

    trace_ready = 1'b0;
    repeat (4) retire_tick();
    trace_ready = 1'b1;
    retire_tick();
    repeat (3) tick();
    check("full_pop_push", 128'(trace_valid), 128'(1'b0));

    trace_ready = 1'b0;
    repeat (300) retire_tick();
    trace_ready = 1'b1;
    repeat (4) tick();
    retire_tick();
    check("drop_sat", 128'(trace_data[71:64]), TRACE_EN ? 128'd255 : '0);

    for (int i = 0; i < 300; i++) begin
      core_retire_valid = 1'($urandom_range(1, 0));
      trace_ready = 1'($urandom_range(1, 0));
      core_retire_pc = $urandom;
      core_retire_insn = $urandom;
      tick();
    end
    core_retire_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
